// File: rtl/i2c_slave_pkg.sv
// Shared constants for the I2C target: one-hot FSM encodings and ACK/NACK SDA levels.
package i2c_slave_pkg;

  localparam logic [8:0] ST_IDLE     = 9'b000000001;
  localparam logic [8:0] ST_ADDR     = 9'b000000010;
  localparam logic [8:0] ST_ADDR_ACK = 9'b000000100;
  localparam logic [8:0] ST_RX       = 9'b000001000;
  localparam logic [8:0] ST_RX_ACK   = 9'b000010000;
  localparam logic [8:0] ST_TX_LOAD  = 9'b000100000;
  localparam logic [8:0] ST_TX       = 9'b001000000;
  localparam logic [8:0] ST_TX_ACK   = 9'b010000000;
  localparam logic [8:0] ST_TX_DONE  = 9'b100000000;

  // SDA output-enable levels: ACK pulls the line low, NACK leaves it released.
  localparam logic ACK_LVL  = 1'b0;
  localparam logic NACK_LVL = 1'b1;

endpackage

// File: rtl/i2c_slave_line_filter.sv
// Two-flop synchronizer plus a FILTER_LEN-sample glitch filter for one open-drain bus line.
module i2c_line_filter #(
  parameter int FILTER_LEN = 3
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic pad_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam logic [3:0] CNT_LAST = 4'(FILTER_LEN - 1);

  logic [1:0] sync_q;
  logic [3:0] cnt_q;
  logic       level_q;
  logic       rise_q;
  logic       fall_q;

  // Any sample that agrees with the stable level restarts the run of differing samples.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync_q  <= 2'b11;
      cnt_q   <= '0;
      level_q <= 1'b1;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], pad_i};
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      if (sync_q[1] == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        cnt_q   <= '0;
        level_q <= sync_q[1];
        rise_q  <= sync_q[1];
        fall_q  <= ~sync_q[1];
      end else begin
        cnt_q <= cnt_q + 4'd1;
      end
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/i2c_slave.sv
// I2C target engine: START/STOP detection, fixed address match, byte receive with ACK,
// and byte transmit with SCL stretching while the application supplies data.
module i2c_slave
  import i2c_slave_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'h50,
  parameter int         FILTER_LEN = 3
) (
  input  logic       clk,
  input  logic       nReset,
  input  logic       ena,
  input  logic       scl_i,
  output logic       scl_o,
  output logic       scl_oen,
  input  logic       sda_i,
  output logic       sda_o,
  output logic       sda_oen,
  input  logic       ack_en,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       tx_req,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       rw,
  output logic       busy,
  output logic       start_det,
  output logic       stop_det
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
    .clk_i(clk), .rst_ni(nReset), .pad_i(scl_i),
    .level_o(scl_lvl), .rise_o(scl_rise), .fall_o(scl_fall)
  );

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
    .clk_i(clk), .rst_ni(nReset), .pad_i(sda_i),
    .level_o(sda_lvl), .rise_o(sda_rise), .fall_o(sda_fall)
  );

  logic [8:0] state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       phase_q, phase_d;
  logic       sda_oen_q, sda_oen_d, scl_oen_q, scl_oen_d;
  logic       rw_q, rw_d, busy_q, busy_d;
  logic       rx_valid_q, rx_valid_d, tx_req_q, tx_req_d;
  logic       start_q, start_d, stop_q, stop_d;
  logic       start_cond, stop_cond;
  logic [7:0] shift_in;

  // A simultaneous SCL edge disqualifies the SDA edge from being a bus condition.
  assign start_cond = sda_fall & scl_lvl & ~scl_rise & ~scl_fall;
  assign stop_cond  = sda_rise & scl_lvl & ~scl_rise & ~scl_fall;
  assign shift_in   = {shift_q[6:0], sda_lvl};

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    rx_data_d  = rx_data_q;
    phase_d    = phase_q;
    sda_oen_d  = sda_oen_q;
    scl_oen_d  = scl_oen_q;
    rw_d       = rw_q;
    busy_d     = busy_q;
    rx_valid_d = 1'b0;
    tx_req_d   = 1'b0;
    start_d    = 1'b0;
    stop_d     = 1'b0;
    if (!ena) begin
      state_d   = ST_IDLE;
      sda_oen_d = 1'b1;
      scl_oen_d = 1'b1;
      busy_d    = 1'b0;
    end else if (start_cond) begin
      state_d   = ST_ADDR;
      bit_cnt_d = 3'd0;
      phase_d   = 1'b0;
      sda_oen_d = 1'b1;
      scl_oen_d = 1'b1;
      start_d   = 1'b1;
      busy_d    = 1'b1;
    end else if (stop_cond) begin
      state_d   = ST_IDLE;
      sda_oen_d = 1'b1;
      scl_oen_d = 1'b1;
      stop_d    = 1'b1;
      busy_d    = 1'b0;
    end else begin
      case (state_q)
        ST_ADDR: if (scl_rise) begin
          shift_d   = shift_in;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            if (shift_q[6:0] == SLAVE_ADDR) begin
              rw_d    = sda_lvl;
              phase_d = 1'b0;
              state_d = ST_ADDR_ACK;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
        ST_ADDR_ACK: if (scl_fall) begin
          if (!phase_q) begin
            sda_oen_d = ACK_LVL;
            phase_d   = 1'b1;
          end else begin
            sda_oen_d = 1'b1;
            phase_d   = 1'b0;
            if (rw_q) begin
              state_d   = ST_TX_LOAD;
              tx_req_d  = 1'b1;
              scl_oen_d = 1'b0;
            end else begin
              state_d = ST_RX;
            end
          end
        end
        ST_RX: if (scl_rise) begin
          shift_d   = shift_in;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            rx_data_d  = shift_in;
            rx_valid_d = 1'b1;
            phase_d    = 1'b0;
            state_d    = ST_RX_ACK;
          end
        end
        ST_RX_ACK: if (scl_fall) begin
          if (!phase_q) begin
            sda_oen_d = ack_en ? ACK_LVL : NACK_LVL;
            phase_d   = 1'b1;
          end else begin
            sda_oen_d = 1'b1;
            phase_d   = 1'b0;
            state_d   = ST_RX;
          end
        end
        // SCL stays stretched low until the application hands over a byte.
        ST_TX_LOAD: if (tx_valid) begin
          shift_d   = tx_data;
          sda_oen_d = tx_data[7];
          scl_oen_d = 1'b1;
          bit_cnt_d = 3'd0;
          state_d   = ST_TX;
        end
        ST_TX: if (scl_fall) begin
          if (bit_cnt_q == 3'd7) begin
            sda_oen_d = 1'b1;
            bit_cnt_d = 3'd0;
            phase_d   = 1'b0;
            state_d   = ST_TX_ACK;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            shift_d   = {shift_q[6:0], 1'b0};
            sda_oen_d = shift_q[6];
          end
        end
        ST_TX_ACK: begin
          if (scl_rise) begin
            if (sda_lvl) state_d = ST_TX_DONE;
            else         phase_d = 1'b1;
          end else if (scl_fall && phase_q) begin
            phase_d   = 1'b0;
            state_d   = ST_TX_LOAD;
            tx_req_d  = 1'b1;
            scl_oen_d = 1'b0;
          end
        end
        ST_IDLE, ST_TX_DONE: ;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!nReset) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'h00;
      rx_data_q  <= 8'h00;
      phase_q    <= 1'b0;
      sda_oen_q  <= 1'b1;
      scl_oen_q  <= 1'b1;
      rw_q       <= 1'b0;
      busy_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      tx_req_q   <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      rx_data_q  <= rx_data_d;
      phase_q    <= phase_d;
      sda_oen_q  <= sda_oen_d;
      scl_oen_q  <= scl_oen_d;
      rw_q       <= rw_d;
      busy_q     <= busy_d;
      rx_valid_q <= rx_valid_d;
      tx_req_q   <= tx_req_d;
      start_q    <= start_d;
      stop_q     <= stop_d;
    end
  end

  assign scl_o     = 1'b0;
  assign sda_o     = 1'b0;
  assign scl_oen   = scl_oen_q;
  assign sda_oen   = sda_oen_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign tx_req    = tx_req_q;
  assign rw        = rw_q;
  assign busy      = busy_q;
  assign start_det = start_q;
  assign stop_det  = stop_q;

endmodule
